// File: rtl/tank_pkg.sv
// tank_pkg: shared types and default constants for the tank level emulator.
package tank_pkg;
    localparam int LEVEL_W = 8;
    localparam int LEVEL_MAX = 255;
    localparam int DEF_LOW_MARK = 64;
    localparam int DEF_MID_MARK = 128;
    localparam int DEF_HIGH_MARK = 192;
    localparam int DEF_FILL_RATE = 4;
    localparam int DEF_SPLINKER_RATE = 3;
    localparam int DEF_DRIPPER_RATE = 1;
    typedef enum logic [1:0] {EMPTY = 2'd0, PARTIAL = 2'd1, FULL = 2'd2} tank_state_e;
endpackage

// File: rtl/level_sensor_bank.sv
// level_sensor_bank: thermometer-coded level sensors, bit 0 = low, 1 = mid, 2 = high.
module level_sensor_bank
    import tank_pkg::*;
#(
    parameter int LOW_MARK = DEF_LOW_MARK,
    parameter int MID_MARK = DEF_MID_MARK,
    parameter int HIGH_MARK = DEF_HIGH_MARK
) (
    input  logic [LEVEL_W-1:0] i_level,
    output logic [2:0]         o_sensors
);
    localparam logic [LEVEL_W-1:0] L_LOW = LEVEL_W'(LOW_MARK);
    localparam logic [LEVEL_W-1:0] L_MID = LEVEL_W'(MID_MARK);
    localparam logic [LEVEL_W-1:0] L_HIGH = LEVEL_W'(HIGH_MARK);

    assign o_sensors = {i_level >= L_HIGH, i_level >= L_MID, i_level >= L_LOW};
endmodule

// File: rtl/tank_level_emulator.sv
// tank_level_emulator: tick-driven tank volume integrator with level sensors and state FSM.
// Optional SENSOR_FAULT_EN adds fault_force to invert individual sensor outputs.
module tank_level_emulator
    import tank_pkg::*;
#(
    parameter int LOW_MARK = DEF_LOW_MARK,
    parameter int MID_MARK = DEF_MID_MARK,
    parameter int HIGH_MARK = DEF_HIGH_MARK,
    parameter int FILL_RATE = DEF_FILL_RATE,
    parameter int SPLINKER_RATE = DEF_SPLINKER_RATE,
    parameter int DRIPPER_RATE = DEF_DRIPPER_RATE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               water_supply_valvule,
    input  logic               splinker_bomb,
    input  logic               dripper_valvule,
`ifdef SENSOR_FAULT_EN
    input  logic [2:0]         fault_force,
`endif
    output logic               low_water_level,
    output logic               mid_water_level,
    output logic               high_water_level,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic               dry_run,
    output logic [1:0]         tank_state
);
    localparam logic signed [9:0] FILL = 10'(FILL_RATE);
    localparam logic signed [9:0] SPL = 10'(SPLINKER_RATE);
    localparam logic signed [9:0] DRIP = 10'(DRIPPER_RATE);
    localparam logic signed [9:0] MAX = 10'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(LEVEL_MAX);

    logic signed [9:0]  w_sum;
    logic [LEVEL_W-1:0] w_next;
    logic [2:0]         w_sens;
    logic [LEVEL_W-1:0] r_level;
    logic [2:0]         r_sens;
    logic               r_ovf;
    logic               r_dry;
    tank_state_e        r_state;

    // Fill and drains net before clamping, so a balanced step never flags.
    assign w_sum = $signed({2'b00, r_level})
                 + (water_supply_valvule ? FILL : 10'sd0)
                 - (splinker_bomb ? SPL : 10'sd0)
                 - (dripper_valvule ? DRIP : 10'sd0);
    assign w_next = w_sum > MAX ? MAX_L : w_sum < 10'sd0 ? '0 : w_sum[LEVEL_W-1:0];

    level_sensor_bank #(
        .LOW_MARK (LOW_MARK),
        .MID_MARK (MID_MARK),
        .HIGH_MARK(HIGH_MARK)
    ) u_sensors (
        .i_level  (w_next),
        .o_sensors(w_sens)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_sens <= '0;
            r_ovf <= 1'b0;
            r_dry <= 1'b0;
            r_state <= EMPTY;
        end else begin
            r_ovf <= tick && (w_sum > MAX);
            r_dry <= tick && (r_level == '0) && (w_sum < 10'sd0);
            if (tick) begin
                r_level <= w_next;
                r_sens <= w_sens;
                r_state <= w_next == '0 ? EMPTY : w_next == MAX_L ? FULL : PARTIAL;
            end
        end
    end

`ifdef SENSOR_FAULT_EN
    assign {high_water_level, mid_water_level, low_water_level} = r_sens ^ fault_force;
`else
    assign {high_water_level, mid_water_level, low_water_level} = r_sens;
`endif
    assign level = r_level;
    assign overflow = r_ovf;
    assign dry_run = r_dry;
    assign tank_state = r_state;
endmodule

// File: tb/tb_tank_level_emulator.sv
// tb_tank_level_emulator: randomized and directed checks against an arithmetic tank model.
module tb_tank_level_emulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic sup = 1'b0;
    logic spl = 1'b0;
    logic drp = 1'b0;
    logic low_water_level, mid_water_level, high_water_level, overflow, dry_run;
    logic [7:0] level;
    logic [1:0] tank_state;
`ifdef SENSOR_FAULT_EN
    logic [2:0] fault_force = 3'b000;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int m_level = 0;
    bit m_ovf = 0;
    bit m_dry = 0;

    tank_level_emulator dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .tick                (tick),
        .water_supply_valvule(sup),
        .splinker_bomb       (spl),
        .dripper_valvule     (drp),
`ifdef SENSOR_FAULT_EN
        .fault_force         (fault_force),
`endif
        .low_water_level     (low_water_level),
        .mid_water_level     (mid_water_level),
        .high_water_level    (high_water_level),
        .level               (level),
        .overflow            (overflow),
        .dry_run             (dry_run),
        .tank_state          (tank_state)
    );

    always #5 clk = ~clk;

    wire [14:0] act = {level, high_water_level, mid_water_level, low_water_level,
                       tank_state, overflow, dry_run};

    function automatic logic [14:0] exp_vec();
        logic [1:0] st;
        st = m_level == 0 ? 2'd0 : m_level == 255 ? 2'd2 : 2'd1;
        return {8'(m_level), m_level >= 192, m_level >= 128, m_level >= 64, st, m_ovf, m_dry};
    endfunction

    task automatic do_tick(input bit s, input bit p, input bit d);
        int sum;
        @(negedge clk);
        sup = s; spl = p; drp = d; tick = 1'b1;
        sum = m_level + (s ? 4 : 0) - (p ? 3 : 0) - (d ? 1 : 0);
        m_ovf = sum > 255;
        m_dry = (m_level == 0) && (sum < 0);
        m_level = sum > 255 ? 255 : sum < 0 ? 0 : sum;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; tick = 1'b0; sup = 0; spl = 0; drp = 0;
        m_level = 0; m_ovf = 0; m_dry = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (act !== 15'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", act, 15'd0);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 48; i++) begin
            do_tick(1, 0, 0);
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL fill_step%0d: got %h want %h", i, act, exp_vec());
            end
        end
        n_cmp++;
        if (act !== {8'd192, 3'b111, 2'd1, 2'b00}) begin
            n_err++;
            $display("FAIL fill_48: got %h want %h", act, {8'd192, 3'b111, 2'd1, 2'b00});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (63) do_tick(1, 0, 0);
        do_tick(1, 0, 0);
        n_cmp++;
        if (act !== {8'd255, 3'b111, 2'd2, 2'b10}) begin
            n_err++;
            $display("FAIL overflow_first: got %h want %h", act, {8'd255, 3'b111, 2'd2, 2'b10});
        end
        @(posedge clk) #1;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_one_cycle: got %b want 0", overflow);
        end
        do_tick(1, 0, 0);
        n_cmp++;
        if (act !== {8'd255, 3'b111, 2'd2, 2'b10}) begin
            n_err++;
            $display("FAIL overflow_again: got %h want %h", act, {8'd255, 3'b111, 2'd2, 2'b10});
        end
    endtask

    task automatic test_dry();
        do_reset();
        do_tick(1, 0, 0);
        repeat (2) do_tick(0, 0, 1);
        n_cmp++;
        if (level !== 8'd2) begin
            n_err++;
            $display("FAIL dry_setup: got %0d want 2", level);
        end
        do_tick(0, 1, 1);
        n_cmp++;
        if (act !== 15'd0) begin
            n_err++;
            $display("FAIL dry_to_empty: got %h want %h", act, 15'd0);
        end
        do_tick(0, 1, 1);
        n_cmp++;
        if (act !== 15'd1) begin
            n_err++;
            $display("FAIL dry_pulse: got %h want %h", act, 15'd1);
        end
        @(posedge clk) #1;
        n_cmp++;
        if (dry_run !== 1'b0) begin
            n_err++;
            $display("FAIL dry_one_cycle: got %b want 0", dry_run);
        end
    endtask

    task automatic test_balance();
        do_reset();
        repeat (32) do_tick(1, 0, 0);
        repeat (10) do_tick(1, 1, 1);
        n_cmp++;
        if (act !== {8'd128, 3'b011, 2'd1, 2'b00}) begin
            n_err++;
            $display("FAIL balance: got %h want %h", act, {8'd128, 3'b011, 2'd1, 2'b00});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (25) do_tick(1, 0, 0);
        @(negedge clk);
        tick = 1'b1; sup = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act !== 15'd0) begin
            n_err++;
            $display("FAIL reset_mid_immediate: got %h want %h", act, 15'd0);
        end
        @(negedge clk);
        rst_n = 1'b1; tick = 1'b0;
        m_level = 0; m_ovf = 0; m_dry = 0;
        do_tick(1, 0, 0);
        n_cmp++;
        if (act !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_mid_restart: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_hold();
        do_reset();
        repeat ($urandom_range(20, 60)) do_tick(1, $urandom_range(0, 1), 0);
        do_tick(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sup = 1'($urandom); spl = 1'($urandom); drp = 1'($urandom);
            m_ovf = 0; m_dry = 0;
            @(posedge clk) #1;
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL hold%0d: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            do_tick(1'($urandom), 1'($urandom), 1'($urandom));
            n_cmp++;
            if (act !== exp_vec()) begin
                n_err++;
                $display("FAIL random%0d: got %h want %h", i, act, exp_vec());
            end
        end
    endtask

`ifdef SENSOR_FAULT_EN
    task automatic test_fault();
        do_reset();
        fault_force = 3'b100;
        #1;
        n_cmp++;
        if ({high_water_level, mid_water_level, low_water_level} !== 3'b100) begin
            n_err++;
            $display("FAIL fault_force: got %b want 100",
                     {high_water_level, mid_water_level, low_water_level});
        end
        fault_force = 3'b000;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_dry();
        test_balance();
        test_reset_mid();
        test_hold();
        test_random();
`ifdef SENSOR_FAULT_EN
        test_fault();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tank_level_emulator.md
TANK_LEVEL_EMULATOR -- requirements
Module: tank_level_emulator

Interface
REQ-001 Parameter: LOW_MARK, 64, level at/above which low_water_level asserts.
REQ-002 Parameter: MID_MARK, 128, level at/above which mid_water_level asserts.
REQ-003 Parameter: HIGH_MARK, 192, level at/above which high_water_level asserts.
REQ-004 Parameter: FILL_RATE, 4, units added per tick while supply valve open.
REQ-005 Parameter: SPLINKER_RATE, 3, units removed per tick while splinker bomb on.
REQ-006 Parameter: DRIPPER_RATE, 1, units removed per tick while dripper valve open.
REQ-007 Port: clk  in  1  sole clock, rising edge.
REQ-008 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-009 Port: tick  in  1  single-cycle rate strobe; level updates only on ticks.
REQ-010 Port: water_supply_valvule  in  1  supply valve command from controller.
REQ-011 Port: splinker_bomb  in  1  sprinkler pump command from controller.
REQ-012 Port: dripper_valvule  in  1  dripper valve command from controller.
REQ-013 Port: low_water_level / mid_water_level / high_water_level  out  1 each  emulated level sensors.
REQ-014 Port: level  out  8  current tank volume, 0..255.
REQ-015 Port: overflow  out  1  one-cycle pulse, fill clipped at 255.
REQ-016 Port: dry_run  out  1  one-cycle pulse, drain requested with level 0.
REQ-017 Port: tank_state  out  2  FSM state (EMPTY=0, PARTIAL=1, FULL=2).

Function
REQ-018 Block SHALL emulate the tank driven by the irrigation controller's actuator outputs, closing the loop to its sensor inputs.
REQ-019 On a clk edge with tick=1, level SHALL become clamp(level + fill - drains, 0, 255), with fill/drains per REQ-004..006, summed in 10-bit signed arithmetic.
REQ-020 With tick=0, level, sensors and tank_state SHALL hold; overflow and dry_run SHALL be 0.
REQ-021 Sensors SHALL be registered from the next level, updating on the same edge as level (1-cycle latency from tick).
REQ-022 Sensor outputs: each bit = (level >= its mark); thermometer-coded, never inconsistent in fault-free operation.
REQ-023 overflow SHALL pulse when unclamped sum > 255; dry_run SHALL pulse when level=0 and any drain is active on a tick.
REQ-024 Simultaneous fill and drains SHALL net before clamping; overflow/dry_run evaluate on net value only.
REQ-025 FSM: EMPTY->PARTIAL when next level>0; PARTIAL->FULL when next level=255; PARTIAL->EMPTY when next level=0; FULL->PARTIAL when next level<255; EMPTY->FULL permitted if net step reaches 255; transitions only on tick edges.
REQ-026 All inputs SHALL be treated as synchronous to clk; no internal synchronizers.

Reset
REQ-027 rst_n low SHALL immediately force level=0, all sensors=0, overflow=0, dry_run=0, tank_state=EMPTY, fault state cleared.
REQ-028 Reset asserted mid-tick SHALL discard the pending update; first update after release uses level 0.

Configuration
REQ-029 Macro SENSOR_FAULT_EN: when defined, adds input fault_force (3 bits, [0]=low,[1]=mid,[2]=high); a set bit SHALL invert that sensor output combinationally after its register, for exercising the controller alarm.
REQ-030 Without SENSOR_FAULT_EN the port SHALL not exist and sensors SHALL follow REQ-022 exactly.

Structure
REQ-031 Shared package tank_pkg SHALL hold the tank_state enum, LEVEL_W=8, LEVEL_MAX=255 and default mark/rate constants.
REQ-032 Sub-module level_sensor_bank (level in, three sensor bits out, mark parameters) is natural; integrator and FSM remain in top.

Verification
REQ-033 Reset, supply valve on, 48 ticks -> level 192, all three sensors 1, tank_state PARTIAL.
REQ-034 Level 252, supply on, one tick -> level 255, overflow pulses 1 cycle, tank_state FULL; next tick -> overflow again, level 255.
REQ-035 Level 2, splinker+dripper on, one tick -> level 0, tank_state EMPTY, no dry_run; next tick -> dry_run pulse, level 0.
REQ-036 Level 128, supply+splinker+dripper on, 10 ticks -> level 128 unchanged, mid sensor stays 1.
REQ-037 Level 100, rst_n low mid-cycle with tick=1 -> outputs zero at once, level 0 after release.
REQ-038 SENSOR_FAULT_EN, level 0, fault_force=3'b100 -> high=1, low=0, mid=0 (inconsistent pattern for controller alarm).
